// File: rtl/mac_serial_host_if.sv
// Pin-level bundle between local request logic, the serial MAC host and the chip model.
// The host (slave modport) takes operand requests and drives/samples the chip pins.
interface mac_serial_host_if #(
  parameter int OP_W  = 8,
  parameter int RES_W = 20
);
  logic             req;
  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic             busy;
  logic             ser_a;
  logic             ser_b;
  logic             in_done;
  logic             start;
  logic             fin;
  logic             res_bit;
  logic             carry_in;
  logic             res_valid;
  logic [RES_W-1:0] result;
  logic             carry;
  logic             timeout;

  modport master (
    output req, op_a, op_b, fin, res_bit, carry_in,
    input  busy, ser_a, ser_b, in_done, start, res_valid, result, carry, timeout
  );

  modport slave (
    input  req, op_a, op_b, fin, res_bit, carry_in,
    output busy, ser_a, ser_b, in_done, start, res_valid, result, carry, timeout
  );
endinterface

// File: rtl/mac_serial_host.sv
// Host side of the bit-serial 8x8 MAC chip: serializes an operand pair, pulses START,
// waits for Finish and deserializes the result and carry back into parallel form.
module mac_serial_host #(
  parameter int OP_W    = 8,
  parameter int RES_W   = 20,
  parameter int TIMEOUT = 1023
) (
  input logic              clock,
  input logic              reset,
  mac_serial_host_if.slave bus
);

  localparam int BCNT_W = $clog2(OP_W + 1);
  localparam int RCNT_W = $clog2(RES_W + 1);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_START, S_WAIT, S_RECV, S_DONE
  } state_t;

  state_t             state_q;
  logic [OP_W-1:0]    sha_q, shb_q;
  logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
  logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic [RES_W-1:0]   rx_q, rx_d;
  logic               carry_cap_q;
  logic               busy_q, ser_a_q, ser_b_q, in_done_q, start_q;
  logic               res_valid_q, carry_q, timeout_q;
  logic [RES_W-1:0]   result_q;

  assign bcnt_d = bcnt_q + 1'b1;
  assign rcnt_d = rcnt_q + 1'b1;
  assign tcnt_d = tcnt_q + 1'b1;
  // Receive shifts in from the top so the first sampled bit lands in bit 0 after RES_W samples.
  assign rx_d   = {bus.res_bit, rx_q[RES_W-1:1]};

  // Transaction FSM with every pin output registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sha_q       <= '0;
      shb_q       <= '0;
      bcnt_q      <= '0;
      rcnt_q      <= '0;
      tcnt_q      <= '0;
      rx_q        <= '0;
      carry_cap_q <= 1'b0;
      busy_q      <= 1'b0;
      ser_a_q     <= 1'b0;
      ser_b_q     <= 1'b0;
      in_done_q   <= 1'b0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            sha_q     <= bus.op_a >> 1;
            shb_q     <= bus.op_b >> 1;
            ser_a_q   <= bus.op_a[0];
            ser_b_q   <= bus.op_b[0];
            in_done_q <= (OP_W == 1);
            bcnt_q    <= '0;
            busy_q    <= 1'b1;
            timeout_q <= 1'b0;
            state_q   <= S_SHIFT;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (bcnt_q == BCNT_W'(OP_W - 1)) begin
            ser_a_q   <= 1'b0;
            ser_b_q   <= 1'b0;
            in_done_q <= 1'b0;
            start_q   <= 1'b1;
            state_q   <= S_START;
          end else begin
            ser_a_q   <= sha_q[0];
            ser_b_q   <= shb_q[0];
            sha_q     <= sha_q >> 1;
            shb_q     <= shb_q >> 1;
            bcnt_q    <= bcnt_d;
            in_done_q <= (bcnt_d == BCNT_W'(OP_W - 1));
          end
        end
        S_START: begin
          tcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.fin) begin
            carry_cap_q <= bus.carry_in;
            rx_q        <= rx_d;
            rcnt_q      <= RCNT_W'(1);
            state_q     <= S_RECV;
          end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
            // Finish never came: report with the previous result and carry untouched.
            timeout_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            tcnt_q <= tcnt_d;
          end
        end
        S_RECV: begin
          rx_q   <= rx_d;
          rcnt_q <= rcnt_d;
          if (rcnt_q == RCNT_W'(RES_W - 1)) begin
            result_q    <= rx_d;
            carry_q     <= carry_cap_q;
            res_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            state_q <= S_RECV;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.ser_a     = ser_a_q;
  assign bus.ser_b     = ser_b_q;
  assign bus.in_done   = in_done_q;
  assign bus.start     = start_q;
  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_mac_serial_host.sv
// Directed plus randomized bench for mac_serial_host; a transaction-level chip model
// drives Finish and the result stream and predicts every observable outcome.
module tb_mac_serial_host;

  localparam int OP_W    = 8;
  localparam int RES_W   = 20;
  localparam int TIMEOUT = 15;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  logic [RES_W-1:0] prev_res;
  logic             prev_carry;

  mac_serial_host_if #(.OP_W(OP_W), .RES_W(RES_W)) bus ();

  mac_serial_host #(.OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {3'b000, bus.busy, bus.ser_a, bus.ser_b, bus.in_done, bus.start,
            bus.res_valid, bus.carry, bus.timeout, bus.result};
  endfunction

  // Reset applied for the current cycle; outputs must be all zero in the next one.
  task automatic do_reset(input string tag);
    reset      = 1'b1;
    bus.req    = 1'b0;
    bus.fin    = 1'b0;
    @(negedge clock);
    chk({tag, "_outs_zero"}, all_outs(), 32'h0);
    reset      = 1'b0;
    prev_res   = '0;
    prev_carry = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus.fin      = 1'b1;
      bus.res_bit  = 1'($urandom);
      @(negedge clock);
      chk({tag, "_idle_quiet"}, {30'h0, bus.busy, bus.res_valid}, 32'h0);
    end
    bus.fin = 1'b0;
  endtask

  // One transaction. n_fin = cycles after START until Finish (0 = never).
  task automatic run_txn(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                         input int n_fin, input logic [RES_W-1:0] rv, input logic cv,
                         input int drop_at, input bit pulse_busy, input bit hold,
                         input int rst_shift, input int rst_recv);
    int               lat;
    int               lat_exp;
    int               budget;
    int               i;
    bit               got;
    logic [RES_W-1:0] res_exp;
    logic             c_exp;
    logic             to_exp;
    bus.req      = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.fin      = 1'b0;
    bus.res_bit  = 1'($urandom);
    bus.carry_in = 1'($urandom);
    lat = 1;
    for (int k = 0; k < OP_W; k++) begin
      @(negedge clock);
      lat++;
      if (!hold) bus.req = 1'b0;
      bus.op_a = OP_W'($urandom);
      bus.op_b = OP_W'($urandom);
      if (k == 0) begin
        chk("busy_rise", {31'h0, bus.busy}, 32'h1);
        chk("timeout_cleared", {31'h0, bus.timeout}, 32'h0);
        chk("result_held", {12'h0, bus.result}, {12'h0, prev_res});
        chk("carry_held", {31'h0, bus.carry}, {31'h0, prev_carry});
      end
      chk("ser_a", {31'h0, bus.ser_a}, {31'h0, a[k]});
      chk("ser_b", {31'h0, bus.ser_b}, {31'h0, b[k]});
      chk("in_done", {31'h0, bus.in_done}, {31'h0, (k == OP_W - 1)});
      chk("start_low", {31'h0, bus.start}, 32'h0);
      if (k == rst_shift) begin
        do_reset("rst_shift");
        return;
      end
    end
    @(negedge clock);
    lat++;
    chk("start_pulse", {28'h0, bus.start, bus.ser_a, bus.ser_b, bus.in_done}, 32'h8);
    budget = (n_fin > 0) ? n_fin + RES_W + 5 : TIMEOUT + 5;
    got = 1'b0;
    for (int t = 0; t < budget; t++) begin
      i = t - n_fin;
      if (n_fin > 0 && i >= 0 && i < RES_W) begin
        bus.fin      = (drop_at < 0 || i < drop_at);
        bus.res_bit  = rv[i];
        bus.carry_in = (i == 0) ? cv : ~cv;
      end else begin
        bus.fin      = 1'b0;
        bus.res_bit  = 1'($urandom);
        bus.carry_in = 1'($urandom);
      end
      if (pulse_busy && t == 1) begin
        bus.req  = 1'b1;
        bus.op_a = OP_W'($urandom);
        bus.op_b = OP_W'($urandom);
      end else if (!hold) begin
        bus.req = 1'b0;
      end
      if (n_fin > 0 && i == rst_recv) begin
        do_reset("rst_recv");
        return;
      end
      @(negedge clock);
      lat++;
      if (bus.res_valid) begin
        got = 1'b1;
        break;
      end
    end
    chk("res_valid_seen", {31'h0, got}, 32'h1);
    if (n_fin == 0) begin
      res_exp = prev_res;
      c_exp   = prev_carry;
      to_exp  = 1'b1;
      lat_exp = 1 + OP_W + 1 + TIMEOUT + 1;
    end else begin
      res_exp = rv;
      c_exp   = cv;
      to_exp  = 1'b0;
      lat_exp = 1 + OP_W + 1 + n_fin + RES_W;
    end
    chk("latency", lat, lat_exp);
    chk("result", {12'h0, bus.result}, {12'h0, res_exp});
    chk("carry", {31'h0, bus.carry}, {31'h0, c_exp});
    chk("timeout", {31'h0, bus.timeout}, {31'h0, to_exp});
    prev_res   = res_exp;
    prev_carry = c_exp;
    bus.fin    = 1'b0;
    if (!hold) bus.req = 1'b0;
    @(negedge clock);
    chk("back_to_idle", {30'h0, bus.busy, bus.res_valid}, 32'h0);
    chk("result_stable", {12'h0, bus.result}, {12'h0, res_exp});
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    prev_res     = '0;
    prev_carry   = 1'b0;
    reset        = 1'b1;
    bus.req      = 1'b0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.fin      = 1'b0;
    bus.res_bit  = 1'b0;
    bus.carry_in = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_state", all_outs(), 32'h0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_after_reset", all_outs(), 32'h0);

    run_txn(8'hA5, 8'h3C, 5, 20'h01C2E, 1'b1, -1, 1'b0, 1'b0, -1, -1);
    run_txn(8'h5A, 8'hC3, 0, 20'h0, 1'b0, -1, 1'b0, 1'b1, -1, -1);
    run_txn(OP_W'($urandom), OP_W'($urandom), 3, RES_W'($urandom), 1'b0, -1, 1'b1, 1'b0, -1, -1);
    run_txn(8'h96, 8'h69, 2, 20'hABCDE, 1'b1, -1, 1'b0, 1'b0, 4, -1);
    run_txn(OP_W'($urandom), OP_W'($urandom), 4, RES_W'($urandom), 1'b1, -1, 1'b0, 1'b0, -1, -1);
    run_txn(8'h0F, 8'hF0, 3, 20'h5A5A5, 1'b1, -1, 1'b0, 1'b0, -1, 10);
    run_txn(OP_W'($urandom), OP_W'($urandom), 1, RES_W'($urandom), 1'b0, -1, 1'b0, 1'b0, -1, -1);
    run_txn(8'hFF, 8'hFF, 2, 20'hFFFFF, 1'b1, 8, 1'b0, 1'b0, -1, -1);
    for (int n = 0; n < 6; n++) begin
      run_txn(OP_W'($urandom), OP_W'($urandom), int'($urandom_range(1, 6)), RES_W'($urandom),
              1'($urandom), (n % 2 == 0) ? int'($urandom_range(1, 19)) : -1,
              1'($urandom), 1'b0, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
